// File: rtl/pc_plus_4_pkg.sv
// Core-wide constants shared by the fetch-stage PC logic and the pipeline-register primitive.
package pc_plus_4_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned INSTR_BYTES = 4;
   localparam logic [XLEN-1:0] PC_RESET = '0;

   // Status bundle carried by the mirror register: {PCPlus4, wrap, misaligned}.
   localparam int unsigned STATUS_W = XLEN + 2;

   function automatic logic is_misaligned(input logic [1:0] pc_lsb);
      return (pc_lsb != 2'b00);
   endfunction

endpackage

// File: rtl/pc_plus_4_reg.sv
// Width-parameterised async-reset register with a valid flag; the core's pipeline-register primitive.
module pc_plus_4_reg
   import pc_plus_4_pkg::*;
#(
   parameter int unsigned       WIDTH     = STATUS_W,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;

   always_comb begin
      data_d  = data_i;
      valid_d = 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_q  <= RESET_VAL;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/pc_plus_4.sv
// Next-sequential-PC adder: combinational PC + INCR with carry-out and alignment flags,
// plus a registered mirror of all three for debug/trace.
module pc_plus_4 #(
   parameter int unsigned XLEN = pc_plus_4_pkg::XLEN,
   parameter int unsigned INCR = pc_plus_4_pkg::INSTR_BYTES
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] PC,
   output logic [XLEN-1:0] PCPlus4,
   output logic [XLEN-1:0] PCPlus4_q,
   output logic            wrap,
   output logic            wrap_q,
   output logic            misaligned,
   output logic            misaligned_q,
   output logic            valid_q
);

   import pc_plus_4_pkg::*;

   localparam int unsigned BUNDLE_W = XLEN + 2;
   localparam logic [BUNDLE_W-1:0] BUNDLE_RESET = {XLEN'(PC_RESET), 1'b0, 1'b0};

   logic [XLEN:0]         sum_ext;
   logic [BUNDLE_W-1:0]   status_d;
   logic [BUNDLE_W-1:0]   status_q;

   // One extra bit on the add so the carry-out becomes the wrap flag directly.
   always_comb begin
      sum_ext    = {1'b0, PC} + (XLEN+1)'(INCR);
      PCPlus4    = sum_ext[XLEN-1:0];
      wrap       = sum_ext[XLEN];
      misaligned = is_misaligned(PC[1:0]);
      status_d   = {PCPlus4, wrap, misaligned};
   end

   pc_plus_4_reg #(
      .WIDTH     (BUNDLE_W),
      .RESET_VAL (BUNDLE_RESET)
   ) u_status_reg (
      .clk_i   (clk),
      .rst_i   (reset),
      .data_i  (status_d),
      .data_o  (status_q),
      .valid_o (valid_q)
   );

   assign {PCPlus4_q, wrap_q, misaligned_q} = status_q;

endmodule

// File: tb/tb_pc_plus_4.sv
// Directed + random checks of pc_plus_4 against a 64-bit arithmetic reference model.
module tb_pc_plus_4;

   logic        clk;
   logic        reset;
   logic [31:0] PC;
   logic [31:0] PCPlus4, PCPlus4_q;
   logic        wrap, wrap_q, misaligned, misaligned_q, valid_q;

   int unsigned total = 0;
   int unsigned bad   = 0;

   pc_plus_4 #(.XLEN(32), .INCR(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .PC           (PC),
      .PCPlus4      (PCPlus4),
      .PCPlus4_q    (PCPlus4_q),
      .wrap         (wrap),
      .wrap_q       (wrap_q),
      .misaligned   (misaligned),
      .misaligned_q (misaligned_q),
      .valid_q      (valid_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] ref_sum(input logic [31:0] pc);
      longint unsigned t;
      t = longint'(pc) + 64'd4;
      return 32'(t % (64'd1 << 32));
   endfunction

   function automatic logic ref_wrap(input logic [31:0] pc);
      longint unsigned t;
      t = longint'(pc) + 64'd4;
      return (t >= (64'd1 << 32));
   endfunction

   function automatic logic ref_mis(input logic [31:0] pc);
      return ((pc % 4) != 0);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_comb(input logic [31:0] pc);
      chk("PCPlus4",    PCPlus4,             ref_sum(pc));
      chk("wrap",       {31'b0, wrap},       {31'b0, ref_wrap(pc)});
      chk("misaligned", {31'b0, misaligned}, {31'b0, ref_mis(pc)});
   endtask

   task automatic check_regs(input logic [31:0] pc);
      chk("PCPlus4_q",    PCPlus4_q,             ref_sum(pc));
      chk("wrap_q",       {31'b0, wrap_q},       {31'b0, ref_wrap(pc)});
      chk("misaligned_q", {31'b0, misaligned_q}, {31'b0, ref_mis(pc)});
      chk("valid_q",      {31'b0, valid_q},      32'd1);
   endtask

   task automatic check_cleared();
      chk("rst PCPlus4_q",    PCPlus4_q,             32'd0);
      chk("rst wrap_q",       {31'b0, wrap_q},       32'd0);
      chk("rst misaligned_q", {31'b0, misaligned_q}, 32'd0);
      chk("rst valid_q",      {31'b0, valid_q},      32'd0);
   endtask

   task automatic apply(input logic [31:0] pc);
      @(negedge clk);
      PC = pc;
      #1 check_comb(pc);
      @(posedge clk);
      #1 check_regs(pc);
   endtask

   logic [31:0] rpc;

   initial begin
      reset = 1'b1;
      PC    = 32'd0;
      #1;
      check_cleared();
      check_comb(32'd0);
      @(posedge clk);
      #1 check_cleared();

      @(negedge clk);
      reset = 1'b0;
      apply(32'd0);

      apply(32'd12345678);
      chk("dec0 sum", PCPlus4, 32'd12345682);
      apply(32'd17291729);
      chk("dec1 sum", PCPlus4, 32'd17291733);
      apply(32'd87654321);
      chk("dec2 sum", PCPlus4, 32'd87654325);

      apply(32'hFFFF_FFFB);
      chk("wrapFB sum", PCPlus4, 32'hFFFF_FFFF);
      apply(32'hFFFF_FFFC);
      chk("wrapFC sum", PCPlus4, 32'h0000_0000);
      chk("wrapFC flag", {31'b0, wrap_q}, 32'd1);
      apply(32'hFFFF_FFFF);
      chk("wrapFF sum", PCPlus4, 32'h0000_0003);
      apply(32'd1);

      // Async reset between edges: registers clear at once, adder keeps tracking PC.
      apply(32'h0000_0100);
      #2 reset = 1'b1;
      #1 check_cleared();
      chk("rst comb sum", PCPlus4, 32'h0000_0104);
      @(posedge clk);
      #1 check_cleared();
      @(negedge clk);
      reset = 1'b0;
      #1 check_cleared();
      @(posedge clk);
      #1 check_regs(32'h0000_0100);
      chk("post-rst sum_q", PCPlus4_q, 32'h0000_0104);

      for (int i = 0; i < 1000; i++) begin
         rpc = $urandom;
         if ((i % 50) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
         apply(rpc);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
